// File: rtl/mips_div_pkg.sv
// Shared DIV/DIVU sequencer types: state encoding, iteration count and operand magnitude helper.
// Also used by the EXE HI/LO mux and the hazard unit.
package mips_div_pkg;

    localparam int DIV_ITER = 32;
    localparam int STATE_W  = 2;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_t;

    // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
    function automatic logic [31:0] div_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EXE <-> divide sequencer request/result bundle; master is the EXE stage, slave is div_ctrl.
interface div_ctrl_if;
    import mips_div_pkg::*;

    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_ready;
    logic [63:0] div_result;
    logic        stall_req;

    modport master (
        output div_start, div_signed, div_annul, div_opa, div_opb,
        input  div_ready, div_result, stall_req
    );

    modport slave (
        input  div_start, div_signed, div_annul, div_opa, div_opb,
        output div_ready, div_result, stall_req
    );

endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer returning {HI=remainder, LO=quotient}.
// Latency: result in cycle DIV_ITER+1 after accept (cycle 2 on divide-by-zero).
// Backpressure: stall_req freezes the front pipeline while busy; result held while div_start stays high.
module div_ctrl
    import mips_div_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [64:0]       work;
    logic [31:0]       opb_mag;
    logic              neg_quot;
    logic              neg_rem;
    logic [63:0]       res_q;

    logic              accept;
    logic              last_iter;
    logic [65:0]       shifted;
    logic [33:0]       diff;
    logic [64:0]       work_step;
    logic [31:0]       quot_fix;
    logic [31:0]       rem_fix;

    assign accept    = (state == IDLE) && bus.div_start && !bus.div_annul;
    assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));

    // One iteration: shift left, trial-subtract the divisor from the upper half.
    assign shifted   = {work, 1'b0};
    assign diff      = shifted[65:32] - {2'b00, opb_mag};
    assign work_step = diff[33] ? shifted[64:0] : {diff[32:0], shifted[31:1], 1'b1};

    assign quot_fix  = neg_quot ? (~work_step[31:0] + 32'd1)  : work_step[31:0];
    assign rem_fix   = neg_rem  ? (~work_step[63:32] + 32'd1) : work_step[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.div_opb == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: state_nxt = bus.div_annul ? IDLE : END;
            // Annul takes priority over the final iteration.
            ON: begin
                if (bus.div_annul) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (!bus.div_start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            work     <= '0;
            opb_mag  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                work     <= {33'b0, div_mag(bus.div_opa, bus.div_signed)};
                opb_mag  <= div_mag(bus.div_opb, bus.div_signed);
                neg_quot <= bus.div_signed && (bus.div_opa[31] ^ bus.div_opb[31]);
                neg_rem  <= bus.div_signed && bus.div_opa[31];
            end else if (state == ON) begin
                work <= work_step;
                cnt  <= cnt + CNT_W'(1);
            end

            if (state != END && state_nxt == END) begin
                res_q <= (state == ON) ? {rem_fix, quot_fix} : 64'h0;
            end
        end
    end

    always_comb begin
        bus.div_ready  = (state == END);
        bus.div_result = (state == END) ? res_q : 64'h0;
        bus.stall_req  = accept || (state == DIVZERO) || (state == ON);
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized + directed bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
    import mips_div_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    div_ctrl_if bus();

    div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int drop_at, input string tag);
        logic [63:0] exp_res;
        int          exp_lat;
        int          rdy_cyc;
        bit          stall_ok;
        logic [63:0] held;
        exp_res  = ref_div(a, b, sgn);
        exp_lat  = (b == 32'd0) ? 2 : DIV_ITER + 1;
        rdy_cyc  = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.div_opa    = a;
        bus.div_opb    = b;
        #1 chk({tag, "_stall_c0"}, 64'(bus.stall_req), 64'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.div_ready) begin
                rdy_cyc = cyc;
                break;
            end
            if (!bus.stall_req) stall_ok = 1'b0;
            if (cyc == 1) begin
                bus.div_opa    = $urandom;
                bus.div_opb    = $urandom;
                bus.div_signed = 1'($urandom);
            end
            if (cyc == drop_at) bus.div_start = 1'b0;
        end
        chk({tag, "_latency"}, 64'(rdy_cyc), 64'(exp_lat));
        chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        if (rdy_cyc != 0) begin
            chk({tag, "_result"}, bus.div_result, exp_res);
            chk({tag, "_stall_end"}, 64'(bus.stall_req), 64'd0);
        end
        held = bus.div_result;
        if (drop_at == 0) begin
            @(negedge clk);
            chk({tag, "_hold_ready"}, 64'(bus.div_ready), 64'd1);
            chk({tag, "_hold_result"}, bus.div_result, held);
            bus.div_start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(bus.div_ready), 64'd0);
        chk({tag, "_idle_result"}, bus.div_result, 64'h0);
        chk({tag, "_idle_stall"}, 64'(bus.stall_req), 64'd0);
    endtask

    task automatic annul_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                             input int at, input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.div_opa    = a;
        bus.div_opb    = b;
        for (int cyc = 1; cyc <= at; cyc++) begin
            @(negedge clk);
            if (bus.div_ready) seen = 1'b1;
            if (cyc == at) bus.div_annul = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_stall_after"}, 64'(bus.stall_req), 64'd0);
        chk({tag, "_ready_after"}, 64'(bus.div_ready), 64'd0);
        bus.div_start = 1'b0;
        bus.div_annul = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.div_ready || bus.stall_req) seen = 1'b1;
        end
        chk({tag, "_no_ready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_annul  = 1'b0;
        bus.div_opa    = '0;
        bus.div_opb    = '0;
        #3;
        chk("reset_ready", 64'(bus.div_ready), 64'd0);
        chk("reset_result", bus.div_result, 64'h0);
        chk("reset_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        chk("divu_100_7_known", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_min_m1");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "divu_max_1");
        run_div(32'd5, 32'd0, 1'b0, 0, "divu_by0");
        run_div(32'h8000_0000, 32'd0, 1'b1, 0, "div_by0");
        run_div(32'd123456, 32'hFFFF_FD0B, 1'b1, 15, "div_drop_start");

        annul_div(32'd1000, 32'd3, 1'b0, 10, "annul_c10");
        run_div(32'd9, 32'd3, 1'b0, 0, "divu_9_3");
        annul_div(32'd1000, 32'd3, 1'b0, 32, "annul_last");
        annul_div(32'd5, 32'd0, 1'b0, 1, "annul_divzero");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.div_start = 1'b1;
        bus.div_opa   = 32'd1000;
        bus.div_opb   = 32'd3;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(bus.div_ready), 64'd0);
        chk("rst_mid_result", bus.div_result, 64'h0);
        bus.div_start = 1'b0;
        #1 chk("rst_mid_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(32'hFFFF_FC18, 32'd7, 1'b1, 0, "after_rst");

        for (int i = 0; i < 25; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom;
                4:       rb = 32'd1;
                default: rb = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 1000))
                                                           : 32'($urandom_range(1, 1000));
            endcase
            rs = 1'($urandom);
            run_div(ra, rb, rs, 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the HI/LO path of the 5-stage MIPS32 pipeline. It accepts a DIV/DIVU request from EXE, runs a 32-iteration radix-2 restoring division, and returns a 64-bit {remainder, quotient} word for the HI/LO write carried down through MEM/WB. It raises a pipeline stall request while busy and supports annulment when the issuing instruction is flushed.

## Interface
- DIV_ITER, 32, iteration count (operand width).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- div_start  in  1  EXE holds high while a DIV/DIVU is pending.
- div_signed  in  1  1 = DIV, 0 = DIVU; sampled with div_start.
- div_annul  in  1  abort current operation (flush).
- div_opa  in  32  dividend (rs); sampled on accept.
- div_opb  in  32  divisor (rt); sampled on accept.
- div_ready  out  1  result valid.
- div_result  out  64  {HI = remainder, LO = quotient}.
- stall_req  out  1  request to freeze PC/IF/ID/EXE.

## Operation
- States: IDLE, DIVZERO, ON, END.
- Accept: in IDLE with div_start=1 and div_annul=0.
  - If div_opb == 0 → DIVZERO.
  - Else → ON: latch signed/unsigned magnitudes, clear counter, load 65-bit working register {33'b0, |opa|}.
  - Magnitudes: for signed operands, a negative value is two's-complemented; 0x80000000 stays 0x80000000 as an unsigned magnitude.
- ON, per cycle:
  - Shift the working register left 1.
  - Trial-subtract |opb| from bits [64:32]; on non-negative difference, write it back and set bit 0 = 1.
  - Counter increments; at counter == DIV_ITER-1, → END.
- END entry, result = {rem, quot}:
  - If signed and opa/opb signs differ, quotient is negated.
  - If signed and opa is negative, remainder is negated.
- DIVZERO: next cycle → END with result 64'h0.
- END: div_ready=1 and div_result is held stable while div_start=1; → IDLE when div_start=0. In IDLE, div_result returns to 0.
- Annul: in ON or DIVZERO with div_annul=1 → IDLE next edge. No div_ready pulse; working state is discarded.
- stall_req (combinational):
  - 1 when (IDLE & div_start & ~div_annul) | DIVZERO | ON.
  - 0 in END, so the issuing instruction advances on the ready cycle.

## Timing
- Reset (async, any state) → IDLE, counter 0, div_ready=0, div_result=0, stall_req=0 once start is low.
- Latency: with start sampled at edge T0, the state is ON for cycles 1..32 and END (div_ready=1) in cycle 33.
- Divide-by-zero: start at T0 → DIVZERO in cycle 1 → END in cycle 2.
- Annul arriving in the same cycle as the final ON iteration wins: → IDLE, no ready.
- div_start dropping in ON without div_annul: the operation completes, END lasts one cycle, then IDLE.
- Back-to-back divides: a new accept is possible only from IDLE, i.e. at least one IDLE cycle between operations.
- Inputs other than div_start/div_annul are ignored outside the accept cycle.

## Structure
- Shared package mips_div_pkg:
  - state enum (IDLE, DIVZERO, ON, END);
  - DIV_ITER;
  - 2-bit state width.
  - It is reused by the EXE HI/LO mux and the hazard unit.
- Single module, no sub-module. The iteration step (shift + trial subtract) is inline combinational logic feeding the working register.

## Test plan
- DIVU 100 / 7 → div_ready in cycle 33, div_result = {32'd2, 32'd14}; stall_req high cycles 0..32, low in 33.
- DIV -7 / 2 (0xFFFFFFF9 / 2) → div_result = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- DIVU 5 / 0 → DIVZERO in cycle 1, div_ready in cycle 2 with result 64'h0.
- Start DIVU 1000 / 3, assert div_annul in cycle 10 → IDLE in cycle 11, stall_req low, div_ready never asserted; a following DIVU 9 / 3 returns {0, 3}.
- Assert rst in cycle 20 of an operation → outputs 0 immediately, IDLE; a fresh divide after release completes normally.
